// File: rtl/transposer_arbiter.sv
// transposer_arbiter: shares one 4x4 byte-transposer between NUM_REQ requesters.
// Whole 4-beat blocks are granted round-robin with the grant held for all
// 4 beats; an in-order ID FIFO tags each returning transposer beat with its
// owning requester.
// Optional feature macro: TP_ARB_ERR_EN adds a sticky 'err' output that flags
// transposer output beats arriving while no block is outstanding.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready.
// Valid never depends on ready. The response path (r_valid) has no
// backpressure.
module transposer_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int IDW       = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ*32-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [31:0]             t_data,
    output logic                    t_valid,
    input  logic                    t_ready,
    input  logic [31:0]             r_data,
    input  logic                    r_valid,
    output logic [31:0]             rsp_data,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy,
    output logic                    dbg_state_o
`ifdef TP_ARB_ERR_EN
    ,
    output logic                    err
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [1:0]     beat_cnt_q, beat_cnt_d;
    logic [1:0]     rsp_cnt_q, rsp_cnt_d;

    logic [IDW-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           fifo_empty, fifo_full;
    logic           push, pop;
    logic           rsp_adv;

    logic [IDW-1:0] scan_idx [NUM_REQ];
    logic           arb_found;
    logic [IDW-1:0] arb_id;
    logic [31:0]    sel_data;
    logic           sel_valid;
    logic [IDW-1:0] next_rr;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign next_rr     = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);
    assign dbg_state_o = (state_q == BURST);

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx[k] = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_found && req_valid[scan_idx[k]]) begin
                arb_found = 1'b1;
                arb_id    = scan_idx[k];
            end
        end
    end

    // Select the granted requester's word and valid.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id_q == IDW'(i)) begin
                sel_data  = req_data[i*32 +: 32];
                sel_valid = req_valid[i];
            end
        end
    end

    // Arbiter FSM: next state, grant bookkeeping and transposer-side outputs.
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        push       = 1'b0;
        t_valid    = 1'b0;
        t_data     = '0;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                // Full check uses the pre-pop count; a freed slot is used next cycle.
                if (arb_found && !fifo_full) begin
                    gnt_id_d = arb_id;
                    push     = 1'b1;
                    state_d  = BURST;
                end
            end
            BURST: begin
                t_valid             = sel_valid;
                t_data              = sel_data;
                req_ready[gnt_id_q] = t_ready;
                if (sel_valid && t_ready) begin
                    if (beat_cnt_q == 2'd3) begin
                        beat_cnt_d = '0;
                        rr_ptr_d   = next_rr;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response path: pass-through data, tag with FIFO head, count beats.
    always_comb begin
        rsp_data = r_data;
        rsp_id   = fifo_mem_q[rd_ptr_q];
`ifdef TP_ARB_ERR_EN
        rsp_adv   = r_valid && !fifo_empty;
        rsp_valid = rsp_adv;
`else
        rsp_adv   = r_valid;
        rsp_valid = r_valid;
`endif
        rsp_cnt_d = rsp_adv ? rsp_cnt_q + 2'd1 : rsp_cnt_q;
        pop       = rsp_adv && (rsp_cnt_q == 2'd3) && !fifo_empty;
        busy      = (state_q != IDLE) || !fifo_empty;
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_id_q   <= '0;
            beat_cnt_q <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_id_q   <= gnt_id_d;
            beat_cnt_q <= beat_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
        end
    end

    // ID FIFO: push on grant, pop on the 4th response beat; both may happen together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= gnt_id_d;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

`ifdef TP_ARB_ERR_EN
    // Sticky orphan-response flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (r_valid && fifo_empty) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
